sl_preceptron_feeder: RTL and testbench
=======================================

# sl_preceptron_feeder

Input staging block that sits directly upstream of `sl_preceptron_top`. It accepts the feature vector as a byte stream with a valid/ready handshake and buffers one complete vector of `VECTOR_LENGTH` elements. It then replays the vector to the perceptron as an unbroken burst of `DATA_IN_LANES`-wide words on `data_valid`/`data_in`, and holds a guard gap between vectors so the MAC can drain.

## Interface
Parameters:
- `DATA_IN_LANES`, 4, bytes packed per output word
- `DATA_IN_WIDTH`, 8, bits per element
- `VECTOR_LENGTH`, 64, elements per vector; must be a multiple of `DATA_IN_LANES`
- `GAP_CYCLES`, 4, idle cycles after each burst; 0 is legal
- `WORDS`, derived, `VECTOR_LENGTH/DATA_IN_LANES`

Ports:
- `clk` in 1: single clock; all logic on the rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `s_valid` in 1: input element valid.
- `s_ready` out 1: feeder can accept an element.
- `s_data` in `DATA_IN_WIDTH`: element value.
- `s_last` in 1: marks the final element of a vector; used only with the frame-check feature.
- `data_valid` out 1: output word valid; goes to the perceptron.
- `data_in` out `DATA_IN_LANES*DATA_IN_WIDTH`: packed word; goes to the perceptron.
- `busy` out 1: high in BURST and GAP.
- `vec_count` out 16: number of vectors fully emitted; wraps at 65535 → 0.
- `err_frame` out 1: one-cycle pulse on a framing error.
- `err_count` out 8: framing errors seen; saturates at 255.

## Operation
- Reset values: state = FILL, byte index 0, `s_ready`=0 while `rst` is high, `data_valid`=0, `data_in`=0, `busy`=0, `vec_count`=0, `err_frame`=0, `err_count`=0.
- Storage is a buffer of `WORDS` entries, each `DATA_IN_LANES*DATA_IN_WIDTH` bits wide.
- Packing: element k is written to word k/`DATA_IN_LANES`, lane k%`DATA_IN_LANES`. Lane 0 occupies bits [7:0] and lane 3 occupies bits [31:24].
- State FILL:
  - `s_ready`=1.
  - An element is accepted when `s_valid`&&`s_ready` at a rising edge, and the index increments.
  - On accepting element `VECTOR_LENGTH-1`: index clears and the state moves to BURST.
- State BURST:
  - `s_ready`=0, `busy`=1.
  - Words 0..`WORDS-1` are emitted on consecutive cycles with `data_valid`=1. There are no bubbles.
  - On the last word, `vec_count` increments.
  - Next state is GAP, or FILL directly if `GAP_CYCLES`=0.
- State GAP:
  - `data_valid`=0, `data_in`=0, `s_ready`=0.
  - Lasts exactly `GAP_CYCLES` cycles, then the state moves to FILL.
- `data_in` is forced to 0 whenever `data_valid`=0.
- An asserted reset in any state aborts the current vector immediately; buffered data is discarded and all outputs return to their reset values.

## Timing
- `s_ready` is registered and rises in the first cycle after `rst` is released.
- Latency: word 0 appears with `data_valid`=1 in the cycle immediately following the edge that accepts the final element.
- The burst is exactly `WORDS` cycles long; for the defaults that is 16.
- Vector-to-vector period is `VECTOR_LENGTH` accept cycles + `WORDS` + `GAP_CYCLES`, given full-rate input.
- Input stalls (`s_valid`=0) only stretch FILL and never affect the burst.
- `s_ready` falls in the same cycle `data_valid` rises, with no extra cycle between them.

## Configuration
- `SL_FEEDER_FRAME_CHECK_EN` defined:
  - `s_last` is checked on every accepted element.
  - **Early last:** `s_last`=1 on an index below `VECTOR_LENGTH-1`. The error is flagged and the partial vector is dropped; the next element is index 0.
  - **Missing last:** `s_last`=0 on index `VECTOR_LENGTH-1`. The error is flagged, the vector is dropped, and the state stays in FILL; the next element is index 0.
  - A flagged error pulses `err_frame` in the cycle after the offending accept and increments `err_count` (saturating).
  - A dropped vector never bursts and does not increment `vec_count`.
- `SL_FEEDER_FRAME_CHECK_EN` not defined:
  - `s_last` is ignored.
  - `err_frame` and `err_count` are tied to 0.
  - Framing is by count only.

## Test plan
- **Reset, then 64 elements 0..63 at full rate.** Required: 16 consecutive valid words starting the cycle after the last accept; word 0 = 0x03020100 and word 15 = 0x3F3E3D3C; `vec_count`=1.
- **Input with `s_valid` toggling every other cycle.** Required: the same 16 words, still contiguous; `s_ready`=0 for exactly 16+4 cycles after the final accept.
- **Back-to-back vectors, `GAP_CYCLES`=0.** Required: the `data_valid` burst is followed by `s_ready`=1 on the next cycle; the second vector's word 0 matches its elements.
- **Assert `rst` during cycle 8 of the burst.** Required: `data_valid`=0 and `data_in`=0 immediately; `vec_count`=0; after release, a fresh vector produces a correct burst.
- **With the macro: `s_last` on element 10, then a correct 64-element vector.** Required: a single `err_frame` pulse; `err_count`=1; only one burst, holding the second vector's data.
- **With the macro: 64 elements without `s_last`.** Required: `err_frame` pulses once; no burst occurs; `vec_count` is unchanged.

Source files
------------

// File: rtl/sl_preceptron_feeder.sv
// sl_preceptron_feeder: buffers one byte-stream vector and replays it as a word burst.
// Define SL_FEEDER_FRAME_CHECK_EN to enable s_last framing checks.
module sl_preceptron_feeder #(
    parameter int DATA_IN_LANES = 4,
    parameter int DATA_IN_WIDTH = 8,
    parameter int VECTOR_LENGTH = 64,
    parameter int GAP_CYCLES    = 4,
    parameter int WORDS         = VECTOR_LENGTH / DATA_IN_LANES
) (
    input  logic                                   clk,
    input  logic                                   rst,
    input  logic                                   s_valid,
    output logic                                   s_ready,
    input  logic [DATA_IN_WIDTH-1:0]               s_data,
    input  logic                                   s_last,
    output logic                                   data_valid,
    output logic [DATA_IN_LANES*DATA_IN_WIDTH-1:0] data_in,
    output logic                                   busy,
    output logic [15:0]                            vec_count,
    output logic                                   err_frame,
    output logic [7:0]                             err_count
);
    localparam int WORD_W = DATA_IN_LANES * DATA_IN_WIDTH;
    localparam int IDX_W  = (VECTOR_LENGTH > 1) ? $clog2(VECTOR_LENGTH) : 1;
    localparam int PTR_W  = (WORDS > 1) ? $clog2(WORDS) : 1;
    localparam int GAP_W  = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

    localparam logic [1:0] FILL  = 2'd0;
    localparam logic [1:0] BURST = 2'd1;
    localparam logic [1:0] GAP   = 2'd2;

    logic [1:0]        state;
    logic [IDX_W-1:0]  idx;
    logic [PTR_W-1:0]  ptr;
    logic [GAP_W-1:0]  gap_cnt;
    logic [WORD_W-1:0] mem [WORDS];
    logic [WORD_W-1:0] first_word;
    logic [PTR_W-1:0]  wr_word;
    int                wr_lane;
    logic              accept;
    logic              last_idx;
    logic              frame_bad;

    assign accept   = s_valid && s_ready;
    assign last_idx = (idx == IDX_W'(VECTOR_LENGTH - 1));
    assign wr_word  = PTR_W'(int'(idx) / DATA_IN_LANES);
    assign wr_lane  = int'(idx) % DATA_IN_LANES;
    assign busy     = (state != FILL);

`ifdef SL_FEEDER_FRAME_CHECK_EN
    assign frame_bad = s_last ^ last_idx;
`else
    logic unused_last;
    assign unused_last = s_last;
    assign frame_bad   = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (accept)
            mem[wr_word][wr_lane*DATA_IN_WIDTH +: DATA_IN_WIDTH] <= s_data;
    end

    // Word 0 may still be in flight when the final element lands (WORDS == 1).
    always_comb begin
        first_word = mem[0];
        if (wr_word == '0)
            first_word[wr_lane*DATA_IN_WIDTH +: DATA_IN_WIDTH] = s_data;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= FILL;
            idx        <= '0;
            ptr        <= '0;
            gap_cnt    <= '0;
            s_ready    <= 1'b0;
            data_valid <= 1'b0;
            data_in    <= '0;
            vec_count  <= '0;
            err_frame  <= 1'b0;
            err_count  <= '0;
        end else begin
            err_frame <= 1'b0;
            case (state)
                FILL: begin
                    s_ready <= 1'b1;
                    if (accept) begin
                        if (frame_bad) begin
                            idx       <= '0;
                            err_frame <= 1'b1;
                            if (err_count != 8'hFF)
                                err_count <= err_count + 1'b1;
                        end else if (last_idx) begin
                            idx        <= '0;
                            ptr        <= '0;
                            state      <= BURST;
                            s_ready    <= 1'b0;
                            data_valid <= 1'b1;
                            data_in    <= first_word;
                        end else begin
                            idx <= idx + 1'b1;
                        end
                    end
                end
                BURST: begin
                    if (ptr == PTR_W'(WORDS - 1)) begin
                        data_valid <= 1'b0;
                        data_in    <= '0;
                        vec_count  <= vec_count + 1'b1;
                        ptr        <= '0;
                        gap_cnt    <= '0;
                        if (GAP_CYCLES == 0) begin
                            state   <= FILL;
                            s_ready <= 1'b1;
                        end else begin
                            state <= GAP;
                        end
                    end else begin
                        ptr     <= ptr + 1'b1;
                        data_in <= mem[ptr + 1'b1];
                    end
                end
                GAP: begin
                    if (gap_cnt == GAP_W'(GAP_CYCLES - 1)) begin
                        state   <= FILL;
                        s_ready <= 1'b1;
                    end else begin
                        gap_cnt <= gap_cnt + 1'b1;
                    end
                end
                default: state <= FILL;
            endcase
        end
    end
endmodule

// File: tb/tb_sl_preceptron_feeder.sv
// Directed bench for sl_preceptron_feeder: default-gap instance plus a zero-gap instance.
// Framing tests run only when SL_FEEDER_FRAME_CHECK_EN is defined.
module tb_sl_preceptron_feeder;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        sv  = 1'b0;
    logic        sl  = 1'b0;
    logic        sel = 1'b0;
    logic [7:0]  sd  = 8'h00;

    logic        rdy_a, dv_a, busy_a, ef_a;
    logic        rdy_b, dv_b, busy_b, ef_b;
    logic [31:0] din_a, din_b;
    logic [15:0] vc_a, vc_b;
    logic [7:0]  ec_a, ec_b;

    logic        rdy, dv, busy, ef;
    logic [31:0] din;
    logic [15:0] vc;
    logic [7:0]  ec;

    int          vectors = 0;
    int          errors  = 0;
    logic [31:0] words [16];

    always #5 clk = ~clk;

    sl_preceptron_feeder #(.GAP_CYCLES(4)) dut (
        .clk(clk), .rst(rst),
        .s_valid(sv && !sel), .s_ready(rdy_a), .s_data(sd), .s_last(sl),
        .data_valid(dv_a), .data_in(din_a), .busy(busy_a),
        .vec_count(vc_a), .err_frame(ef_a), .err_count(ec_a)
    );

    sl_preceptron_feeder #(.GAP_CYCLES(0)) dut0 (
        .clk(clk), .rst(rst),
        .s_valid(sv && sel), .s_ready(rdy_b), .s_data(sd), .s_last(sl),
        .data_valid(dv_b), .data_in(din_b), .busy(busy_b),
        .vec_count(vc_b), .err_frame(ef_b), .err_count(ec_b)
    );

    assign rdy  = sel ? rdy_b  : rdy_a;
    assign dv   = sel ? dv_b   : dv_a;
    assign din  = sel ? din_b  : din_a;
    assign busy = sel ? busy_b : busy_a;
    assign vc   = sel ? vc_b   : vc_a;
    assign ef   = sel ? ef_b   : ef_a;
    assign ec   = sel ? ec_b   : ec_a;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send_vec(input int base, input int n, input int last_at,
                            input bit toggle);
        int k   = 0;
        int cyc = 0;
        bit ph  = 1'b1;
        bit acc;
        while (k < n && cyc < 1000) begin
            sv  = toggle ? ph : 1'b1;
            ph  = !ph;
            sd  = 8'(base + k);
            sl  = (k == last_at);
            acc = sv && rdy;
            step();
            cyc++;
            if (acc) k++;
        end
        sv = 1'b0;
        sl = 1'b0;
        vectors++;
        if (k != n) begin
            errors++;
            $display("FAIL send: accepted %0d elements, required %0d", k, n);
        end
    endtask

    task automatic check_burst(input int base, input int gap);
        logic [31:0] exp;
        for (int i = 0; i < 16; i++) begin
            exp = {8'(base + 4*i + 3), 8'(base + 4*i + 2),
                   8'(base + 4*i + 1), 8'(base + 4*i)};
            words[i] = din;
            vectors++;
            if (dv !== 1'b1 || din !== exp || rdy !== 1'b0 || busy !== 1'b1) begin
                errors++;
                $display("FAIL burst word %0d: dv=%b data=%h ready=%b busy=%b, required dv=1 data=%h ready=0 busy=1",
                         i, dv, din, rdy, busy, exp);
            end
            step();
        end
        for (int g = 0; g < gap; g++) begin
            vectors++;
            if (dv !== 1'b0 || din !== 32'h0 || rdy !== 1'b0 || busy !== 1'b1) begin
                errors++;
                $display("FAIL gap cycle %0d: dv=%b data=%h ready=%b busy=%b, required 0/0/0/1",
                         g, dv, din, rdy, busy);
            end
            step();
        end
        vectors++;
        if (dv !== 1'b0 || rdy !== 1'b1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL after burst: dv=%b ready=%b busy=%b, required 0/1/0",
                     dv, rdy, busy);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        sv  = 1'b0;
        step();
        vectors++;
        if ({rdy_a, dv_a, busy_a, ef_a, rdy_b, dv_b} !== 6'b0 ||
            din_a !== 32'h0 || vc_a !== 16'h0 || ec_a !== 8'h0) begin
            errors++;
            $display("FAIL reset values: rdy=%b dv=%b busy=%b ef=%b din=%h vc=%0d ec=%0d, required all 0",
                     rdy_a, dv_a, busy_a, ef_a, din_a, vc_a, ec_a);
        end
        rst = 1'b0;
        vectors++;
        if (rdy_a !== 1'b0) begin
            errors++;
            $display("FAIL ready before edge: %b, required 0", rdy_a);
        end
        step();
        vectors++;
        if (rdy_a !== 1'b1 || rdy_b !== 1'b1) begin
            errors++;
            $display("FAIL ready rise: a=%b b=%b, required 1/1", rdy_a, rdy_b);
        end
    endtask

    task automatic test_full_rate();
        sel = 1'b0;
        send_vec(0, 64, 63, 1'b0);
        check_burst(0, 4);
        vectors++;
        if (words[0] !== 32'h03020100 || words[15] !== 32'h3F3E3D3C) begin
            errors++;
            $display("FAIL full-rate words: w0=%h w15=%h, required 03020100/3f3e3d3c",
                     words[0], words[15]);
        end
        vectors++;
        if (vc !== 16'd1) begin
            errors++;
            $display("FAIL full-rate vec_count: %0d, required 1", vc);
        end
    endtask

    task automatic test_stall();
        sel = 1'b0;
        send_vec(8'h40, 64, 63, 1'b1);
        check_burst(8'h40, 4);
        vectors++;
        if (vc !== 16'd2) begin
            errors++;
            $display("FAIL stall vec_count: %0d, required 2", vc);
        end
    endtask

    task automatic test_reset_burst();
        sel = 1'b0;
        send_vec(8'h55, 64, 63, 1'b0);
        for (int i = 0; i < 7; i++) step();
        rst = 1'b1;
        #1;
        vectors++;
        if (dv !== 1'b0 || din !== 32'h0 || vc !== 16'h0 ||
            rdy !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL mid-burst reset: dv=%b data=%h vc=%0d ready=%b busy=%b, required all 0",
                     dv, din, vc, rdy, busy);
        end
        step();
        rst = 1'b0;
        step();
        send_vec(8'h80, 64, 63, 1'b0);
        check_burst(8'h80, 4);
        vectors++;
        if (vc !== 16'd1) begin
            errors++;
            $display("FAIL post-reset vec_count: %0d, required 1", vc);
        end
    endtask

    task automatic test_back_to_back();
        sel = 1'b1;
        send_vec(8'h10, 64, 63, 1'b0);
        check_burst(8'h10, 0);
        send_vec(8'hA0, 64, 63, 1'b0);
        check_burst(8'hA0, 0);
        vectors++;
        if (words[0] !== 32'hA3A2A1A0 || vc !== 16'd2) begin
            errors++;
            $display("FAIL back-to-back: w0=%h vc=%0d, required a3a2a1a0/2",
                     words[0], vc);
        end
        sel = 1'b0;
    endtask

`ifdef SL_FEEDER_FRAME_CHECK_EN
    task automatic test_early_last();
        sel = 1'b0;
        send_vec(0, 11, 10, 1'b0);
        vectors++;
        if (ef !== 1'b1 || dv !== 1'b0 || rdy !== 1'b1) begin
            errors++;
            $display("FAIL early-last pulse: ef=%b dv=%b ready=%b, required 1/0/1",
                     ef, dv, rdy);
        end
        step();
        vectors++;
        if (ef !== 1'b0 || ec !== 8'd1) begin
            errors++;
            $display("FAIL early-last after: ef=%b ec=%0d, required 0/1", ef, ec);
        end
        send_vec(8'h20, 64, 63, 1'b0);
        check_burst(8'h20, 4);
        vectors++;
        if (vc !== 16'd2 || ec !== 8'd1) begin
            errors++;
            $display("FAIL early-last recovery: vc=%0d ec=%0d, required 2/1", vc, ec);
        end
    endtask

    task automatic test_missing_last();
        int seen = 0;
        sel = 1'b0;
        send_vec(8'h30, 64, -1, 1'b0);
        vectors++;
        if (ef !== 1'b1 || dv !== 1'b0 || busy !== 1'b0 || rdy !== 1'b1) begin
            errors++;
            $display("FAIL missing-last pulse: ef=%b dv=%b busy=%b ready=%b, required 1/0/0/1",
                     ef, dv, busy, rdy);
        end
        step();
        vectors++;
        if (ef !== 1'b0 || ec !== 8'd2) begin
            errors++;
            $display("FAIL missing-last after: ef=%b ec=%0d, required 0/2", ef, ec);
        end
        for (int i = 0; i < 20; i++) begin
            if (dv === 1'b1) seen++;
            step();
        end
        vectors++;
        if (seen != 0 || vc !== 16'd2) begin
            errors++;
            $display("FAIL missing-last burst: valid cycles=%0d vc=%0d, required 0/2",
                     seen, vc);
        end
    endtask
`else
    task automatic test_ignore_last();
        sel = 1'b0;
        send_vec(8'h20, 64, 10, 1'b0);
        check_burst(8'h20, 4);
        vectors++;
        if (vc !== 16'd2 || ec !== 8'd0 || ef !== 1'b0) begin
            errors++;
            $display("FAIL ignore-last: vc=%0d ec=%0d ef=%b, required 2/0/0",
                     vc, ec, ef);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_full_rate();
        test_stall();
        test_reset_burst();
        test_back_to_back();
`ifdef SL_FEEDER_FRAME_CHECK_EN
        test_early_last();
        test_missing_last();
`else
        test_ignore_last();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end
endmodule
